uio_bus_arbiter: RTL and testbench

UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

---
 rtl/uio_arb_pkg.sv | 21 ++
 rtl/uio_bus_arbiter_rr.sv | 18 +
 rtl/uio_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the two-requester uio pad arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_t;

  localparam int HOLD_DEFAULT = 2;
  localparam int TURN_DEFAULT = 1;
  localparam int CNT_W        = 4;

  // Select the byte belonging to a one-hot requester.
  function automatic logic [7:0] pick_byte(input logic [1:0] onehot,
                                           input logic [7:0] byte0,
                                           input logic [7:0] byte1);
    return onehot[1] ? byte1 : byte0;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr.sv
// Two-way round-robin picker; ptr names the requester that wins a tie.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uio_bus_arbiter.sv
// Arbitrates two requesters onto the shared uio pads (write drives, read samples).
// Optional UIO_ARB_LOCK_EN adds lock[1:0] for back-to-back same-direction regrants.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_DEFAULT,
  parameter int TURN_CYCLES = TURN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
`ifdef UIO_ARB_LOCK_EN
  input  logic [1:0] lock,
`endif
  input  logic [1:0] req,
  input  logic [1:0] dir,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       grant_reg, grant_next;
  logic             dir_reg, dir_next;
  logic [7:0]       wdata_reg, wdata_next;
  logic [7:0]       rdata_reg, rdata_next;
  logic [1:0]       done_reg, done_next;
  logic             ptr_reg, ptr_next;
  logic [1:0]       sync_reg;
  logic             rst_hold;
  logic [1:0]       arb_req, arb_gnt;
  logic             arb_valid;

  // Assertion is immediate; release is held off for two clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], 1'b0};
    end
  end
  assign rst_hold = sync_reg[1];

  rr_arbiter2 u_rr (
    .req   (arb_req),
    .ptr   (ptr_reg),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      grant_reg <= '0;
      dir_reg   <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      done_reg  <= '0;
      ptr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      dir_reg   <= dir_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      done_reg  <= done_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    dir_next   = dir_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    done_next  = 2'b00;
    ptr_next   = ptr_reg;
    arb_req    = 2'b00;

    unique case (state_reg)
      IDLE: begin
        // The requester just completing still holds req this cycle; skip it.
        arb_req = req & ~done_reg;
        if (arb_valid) begin
          state_next = ACCESS;
          grant_next = arb_gnt;
          dir_next   = |(dir & arb_gnt);
          wdata_next = pick_byte(arb_gnt, wdata0, wdata1);
          cnt_next   = HOLD_LOAD;
          ptr_next   = arb_gnt[0];
        end
      end
      ACCESS: begin
        if (cnt_reg == '0) begin
          done_next = grant_reg;
          if (!dir_reg) begin
            rdata_next = uio_in;
          end
          if (dir_reg && (TURN_CYCLES > 0)) begin
            state_next = TURN;
            cnt_next   = TURN_LOAD;
          end else begin
            state_next = IDLE;
          end
`ifdef UIO_ARB_LOCK_EN
          if (|(lock & req & grant_reg) && (|(dir & grant_reg) == dir_reg)) begin
            state_next = ACCESS;
            cnt_next   = HOLD_LOAD;
            wdata_next = pick_byte(grant_reg, wdata0, wdata1);
            ptr_next   = grant_reg[0];
          end
`endif
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      TURN: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (rst_hold) begin
      state_next = IDLE;
      cnt_next   = '0;
      grant_next = '0;
      dir_next   = 1'b0;
      wdata_next = '0;
      rdata_next = '0;
      done_next  = '0;
      ptr_next   = 1'b0;
    end
  end

  // Pad controls decode straight from state so reset releases them at once.
  assign gnt     = (state_reg == ACCESS) ? grant_reg : 2'b00;
  assign uio_oe  = (state_reg == ACCESS && dir_reg) ? 8'hFF : 8'h00;
  assign uio_out = (state_reg == ACCESS && dir_reg) ? wdata_reg : 8'h00;
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: interval-based access model plus directed literal checks.
module tb_uio_bus_arbiter;

  localparam int H = 2;
  localparam int T = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] dir = 2'b00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out, uio_oe, rdata;
  logic [1:0] gnt, done;
  logic       busy;
`ifdef UIO_ARB_LOCK_EN
  logic [1:0] lock = 2'b00;
`endif

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  uio_bus_arbiter #(.HOLD_CYCLES(H), .TURN_CYCLES(T)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef UIO_ARB_LOCK_EN
    .lock    (lock),
`endif
    .req     (req),
    .dir     (dir),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .gnt     (gnt),
    .done    (done),
    .rdata   (rdata),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: each access is an interval of cycles [acc_s, acc_e]; busy spans to busy_end.
  int         k = 0;
  int         acc_s = 1, acc_e = 0, busy_end = 0, free_at = 1 << 30;
  int         done_at = -1, rd_at = -1;
  logic [1:0] own = 2'b00, done_who = 2'b00;
  logic       wr = 1'b0, ptr = 1'b0;
  logic [7:0] wd = 8'h00, rd_exp = 8'h00, rd_nv = 8'h00;

  task automatic start_acc(input int w);
    own      = (w == 1) ? 2'b10 : 2'b01;
    wr       = dir[w];
    wd       = (w == 1) ? wdata1 : wdata0;
    acc_s    = k + 1;
    acc_e    = k + H;
    busy_end = k + H + 1 + (wr ? T : 0);
    free_at  = busy_end;
    ptr      = (w == 0);
  endtask

  always @(negedge clk) begin
    logic [1:0] elig, e_gnt, e_done;
    logic [7:0] e_oe, e_out;
    logic       e_busy, in_acc;
    int         w;
    k++;
    if (rst) begin
      acc_s = 1; acc_e = 0; busy_end = 0; free_at = k + 3;
      done_at = -1; rd_at = -1; rd_exp = 8'h00; ptr = 1'b0;
    end
    if (k == rd_at) rd_exp = rd_nv;
    in_acc = (k >= acc_s) && (k <= acc_e);
    e_gnt  = in_acc ? own : 2'b00;
    e_oe   = (in_acc && wr) ? 8'hFF : 8'h00;
    e_out  = (in_acc && wr) ? wd : 8'h00;
    e_busy = (k >= acc_s) && (k < busy_end);
    e_done = (k == done_at) ? done_who : 2'b00;
    check($sformatf("model gnt c%0d", k), 32'(gnt), 32'(e_gnt));
    check($sformatf("model uio_oe c%0d", k), 32'(uio_oe), 32'(e_oe));
    check($sformatf("model uio_out c%0d", k), 32'(uio_out), 32'(e_out));
    check($sformatf("model busy c%0d", k), 32'(busy), 32'(e_busy));
    check($sformatf("model done c%0d", k), 32'(done), 32'(e_done));
    check($sformatf("model rdata c%0d", k), 32'(rdata), 32'(rd_exp));
    if (!rst) begin
      if (k == acc_e) begin
        done_at  = k + 1;
        done_who = own;
        if (!wr) begin
          rd_nv = uio_in;
          rd_at = k + 1;
        end
`ifdef UIO_ARB_LOCK_EN
        w = own[1] ? 1 : 0;
        if (lock[w] && req[w] && (dir[w] == wr)) start_acc(w);
`endif
      end
      if (k >= free_at) begin
        elig = req & ~e_done;
        if (elig != 2'b00) begin
          if (elig == 2'b11) w = ptr ? 1 : 0;
          else w = elig[1] ? 1 : 0;
          start_acc(w);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [1:0] seen[$];
  logic [1:0] exp_seq[4];
  logic [1:0] prev_g;

  initial begin
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    tick(2);
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset uio_oe", 32'(uio_oe), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset rdata", 32'(rdata), 32'h0);
    rst = 1'b0;
    tick(4);

    // Single write from requester 0
    req = 2'b01; dir = 2'b01; wdata0 = 8'hA5;
    tick(1);
    $display("txn write0: gnt=%b oe=%h out=%h", gnt, uio_oe, uio_out);
    check("wr0 gnt", 32'(gnt), 32'h1);
    check("wr0 oe c1", 32'(uio_oe), 32'hFF);
    check("wr0 out c1", 32'(uio_out), 32'hA5);
    tick(1);
    check("wr0 oe c2", 32'(uio_oe), 32'hFF);
    tick(1);
    check("wr0 done", 32'(done), 32'h1);
    check("wr0 turn oe", 32'(uio_oe), 32'h0);
    check("wr0 turn busy", 32'(busy), 32'h1);
    req = 2'b00;
    tick(1);
    check("wr0 idle busy", 32'(busy), 32'h0);

    // Single read from requester 1
    req = 2'b10; dir = 2'b00; uio_in = 8'h3C;
    tick(1);
    check("rd1 gnt", 32'(gnt), 32'h2);
    check("rd1 oe", 32'(uio_oe), 32'h0);
    tick(2);
    $display("txn read1: done=%b rdata=%h busy=%b", done, rdata, busy);
    check("rd1 done", 32'(done), 32'h2);
    check("rd1 rdata", 32'(rdata), 32'h3C);
    check("rd1 no turn", 32'(busy), 32'h0);
    req = 2'b00;
    tick(2);

    // Both writing continuously: grants must alternate
    req = 2'b11; dir = 2'b11; wdata0 = 8'h11; wdata1 = 8'h22;
    prev_g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (gnt != 2'b00 && prev_g == 2'b00) seen.push_back(gnt);
      prev_g = gnt;
    end
    req = 2'b00;
    $display("txn rr: %0d grants observed", seen.size());
    check("rr grant count", 32'(seen.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr grant %0d", i), 32'(seen.size() > i ? seen[i] : 2'b00), 32'(exp_seq[i]));
    end
    tick(6);

    // Reset during second access cycle of a write
    req = 2'b01; dir = 2'b01; wdata0 = 8'h5A;
    tick(2);
    check("abort pre oe", 32'(uio_oe), 32'hFF);
    rst = 1'b1; req = 2'b00;
    #1;
    $display("txn abort: oe=%h out=%h gnt=%b", uio_oe, uio_out, gnt);
    check("abort oe async", 32'(uio_oe), 32'h0);
    check("abort out async", 32'(uio_out), 32'h0);
    check("abort gnt async", 32'(gnt), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("abort no done", 32'(done), 32'h0);
    tick(2);
    req = 2'b11; dir = 2'b00; uio_in = 8'h77;
    tick(1);
    check("abort ptr reset", 32'(gnt), 32'h1);
    tick(2);
    check("abort rd done", 32'(done), 32'h1);
    check("abort rd rdata", 32'(rdata), 32'h77);
    req = 2'b10;
    tick(4);
    req = 2'b00;
    tick(3);

    // Request withdrawn right after grant
    req = 2'b01; dir = 2'b00; uio_in = 8'hC3;
    tick(1);
    check("drop gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick(2);
    $display("txn drop: done=%b rdata=%h", done, rdata);
    check("drop done", 32'(done), 32'h1);
    check("drop rdata", 32'(rdata), 32'hC3);
    tick(3);

`ifdef UIO_ARB_LOCK_EN
    // Locked back-to-back writes keep the pads driven
    lock = 2'b01; req = 2'b01; dir = 2'b01; wdata0 = 8'hE7;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lock oe %0d", i), 32'(uio_oe), 32'hFF);
      tick(1);
    end
    $display("txn lock: gnt=%b oe=%h", gnt, uio_oe);
    lock = 2'b00; req = 2'b00;
    tick(6);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
